// File: rtl/spi_fl_pkg.sv
// Shared definitions for the SPI flash arbiter: widths, FSM state encoding
// and the flash opcodes used by the requesters.
package spi_fl_pkg;

  localparam int unsigned SPI_DATA_W = 8;
  localparam int unsigned SPI_COM_W  = 8;
  localparam int unsigned SPI_ADDR_W = 24;
  localparam int unsigned TIMER_W    = 16;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam logic [7:0] SPI_CMD_PP   = 8'h02;
  localparam logic [7:0] SPI_CMD_RDSR = 8'h05;
  localparam logic [7:0] SPI_CMD_WREN = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } spi_fl_state_e;

endpackage

// File: rtl/spi_fl_arbiter_rr_arb2.sv
// Two-way round-robin picker (combinational).
//   req_i  : request bits, bit i = port i
//   last_i : port granted most recently; loses a tie
//   gnt_o  : one-hot grant, zero when nothing is requested
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/spi_fl_arbiter.sv
// Shares one SPI flash master between two requesters. Grants round-robin,
// issues one command/address/data transaction, waits for m_done with a
// timeout and routes a single-cycle response back to the issuing port.
//   clk, rst                        : clock, async active-high reset
//   req_valid/req_ready             : per-port request handshake (grant in IDLE)
//   req_cmd/req_addr/req_wdata      : packed per-port payloads, port i at [i*W +: W]
//   resp_valid/resp_data/resp_err   : one-cycle response to the owning port
//   m_valid/m_ready, m_command/m_address/m_data_in : master request side
//   m_done/m_data_out               : master completion and read data
module spi_fl_arbiter
  import spi_fl_pkg::*;
#(
  parameter int unsigned DATA_W  = SPI_DATA_W,
  parameter int unsigned COM_W   = SPI_COM_W,
  parameter int unsigned ADDR_W  = SPI_ADDR_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*COM_W-1:0]  req_cmd,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [COM_W-1:0]    m_command,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_data_in,
  input  logic                m_done,
  input  logic [DATA_W-1:0]   m_data_out
);

  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

  spi_fl_state_e       state_q, state_d;
  logic [COM_W-1:0]    cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [1:0]          gnt;

  rr_arb2 u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // State and datapath registers; last_q resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    owner_d    = owner_q;
    last_d     = last_q;
    timer_d    = timer_q;
    req_ready  = 2'b00;
    m_valid    = 1'b0;
    resp_valid = 2'b00;

    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (gnt[1]) begin
          cmd_d   = req_cmd[COM_W +: COM_W];
          addr_d  = req_addr[ADDR_W +: ADDR_W];
          wdata_d = req_wdata[DATA_W +: DATA_W];
          owner_d = 1'b1;
          state_d = ST_ISSUE;
        end else if (gnt[0]) begin
          cmd_d   = req_cmd[0 +: COM_W];
          addr_d  = req_addr[0 +: ADDR_W];
          wdata_d = req_wdata[0 +: DATA_W];
          owner_d = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_valid = 1'b1;
        if (m_ready) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Saturating timer; m_done takes priority over a coincident timeout.
        timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        if (m_done) begin
          rdata_d = m_data_out;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = owner_q ? 2'b10 : 2'b01;
        last_d     = owner_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_command = cmd_q;
  assign m_address = addr_q;
  assign m_data_in = wdata_q;
  assign resp_data = rdata_q;
  assign resp_err  = err_q;

endmodule
